// File: rtl/lcd_msg_sender.sv
// Host-side LCD message initiator: converts a signed 16-bit result (or an error
// flag) to decimal ASCII and strobes the bytes out over the Lcd_data/lcdstrb/MBusy handshake.
module lcd_msg_sender #(
  parameter int INIT_CYCLES = 2_000_000,
  parameter int GAP_CYCLES  = 2
) (
  input  logic        CLK_27,
  input  logic        RESET,
  input  logic [15:0] value,
  input  logic        err,
  input  logic        line2,
  input  logic        req,
  input  logic        MBusy,
  output logic [7:0]  Lcd_data,
  output logic        lcdstrb,
  output logic        ready,
  output logic        done,
  output logic [2:0]  dbg_state_o
);

  // Handshake: a byte on Lcd_data is valid in the single cycle lcdstrb=1 and stays
  // held until the next strobe; a new strobe is only issued after MBusy is seen low.
  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_CONV  = 3'd2,
    S_LOAD  = 3'd3,
    S_STRB  = 3'd4,
    S_GAP   = 3'd5,
    S_WAITB = 3'd6
  } state_t;

  localparam int MAXC = (INIT_CYCLES > GAP_CYCLES) ? INIT_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC < 16) ? 5 : $clog2(MAXC + 2);
  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] CONV_LAST = CW'(15);

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [19:0] bcd_q, bcd_d;
  logic [15:0] bin_q, bin_d;
  logic        err_q, err_d;
  logic        line2_q, line2_d;
  logic        neg_q, neg_d;
  logic [7:0]  msg_q [8];
  logic [7:0]  msg_d [8];
  logic [2:0]  len_q, len_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;

  logic [7:0]  ld_msg [8];
  logic [2:0]  ld_len;

  // Message image built from the finished BCD digits; leading zeros dropped, "0" kept.
  always_comb begin
    logic [3:0] dig;
    logic       lead;
    for (int i = 0; i < 8; i++) ld_msg[i] = 8'h00;
    ld_len = 3'd1;
    lead   = 1'b0;
    dig    = 4'd0;
    ld_msg[0] = line2_q ? 8'hC0 : 8'h58;
    if (err_q) begin
      ld_msg[1] = 8'h45;
      ld_msg[2] = 8'h72;
      ld_msg[3] = 8'h72;
      ld_len    = 3'd4;
    end else begin
      if (neg_q) begin
        ld_msg[ld_len] = 8'h2D;
        ld_len = ld_len + 3'd1;
      end
      for (int k = 4; k >= 0; k--) begin
        dig = bcd_q[4*k +: 4];
        if (dig != 4'd0 || lead || k == 0) begin
          lead = 1'b1;
          ld_msg[ld_len] = {4'h3, dig};
          ld_len = ld_len + 3'd1;
        end
      end
    end
  end

  always_comb begin
    logic [19:0] adj;
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    err_d   = err_q;
    line2_d = line2_q;
    neg_d   = neg_q;
    msg_d   = msg_q;
    len_d   = len_q;
    idx_d   = idx_q;
    data_d  = data_q;
    done_d  = 1'b0;
    adj     = bcd_q;
    for (int k = 0; k < 5; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    unique case (state_q)
      S_INIT: begin
        if (cnt_q == INIT_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (req && !done_q) begin
          err_d   = err;
          line2_d = line2;
          neg_d   = value[15];
          bin_d   = value[15] ? (16'd0 - value) : value;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        bcd_d = {adj[18:0], bin_q[15]};
        bin_d = {bin_q[14:0], 1'b0};
        if (cnt_q == CONV_LAST) begin
          cnt_d   = '0;
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LOAD: begin
        msg_d   = ld_msg;
        len_d   = ld_len;
        idx_d   = 3'd0;
        data_d  = ld_msg[0];
        state_d = S_STRB;
      end
      S_STRB: begin
        cnt_d   = '0;
        state_d = (GAP_CYCLES == 0) ? S_WAITB : S_GAP;
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_WAITB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAITB: begin
        if (!MBusy) begin
          if (idx_q < len_q - 3'd1) begin
            idx_d   = idx_q + 3'd1;
            data_d  = msg_q[idx_q + 3'd1];
            state_d = S_STRB;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge CLK_27 or posedge RESET) begin
    if (RESET) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      line2_q <= 1'b0;
      neg_q   <= 1'b0;
      msg_q   <= '{default: 8'h00};
      len_q   <= 3'd0;
      idx_q   <= 3'd0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      line2_q <= line2_d;
      neg_q   <= neg_d;
      msg_q   <= msg_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  // ready stays low during the done cycle so a new request starts one cycle later.
  assign Lcd_data    = data_q;
  assign lcdstrb     = (state_q == S_STRB);
  assign ready       = (state_q == S_IDLE) && !done_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule
